pll_seq: RTL

PLL_SEQ -- requirements
Module: pll_seq

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/pll_seq_sync.sv | 24 ++
 rtl/pll_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encoding, parameter defaults and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int DEF_RST_CYC   = 16;
  localparam int DEF_LOCK_FILT = 1024;
  localparam int DEF_LOCK_TMO  = 500000;
  localparam int DEF_MAX_RETRY = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Two-flop synchronizer for a single asynchronous level input; clears to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a filtered lock, then releases
// the downstream reset; retries on lock timeout and latches FAULT after too many.
module pll_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYC   = DEF_RST_CYC,
  parameter int LOCK_FILT = DEF_LOCK_FILT,
  parameter int LOCK_TMO  = DEF_LOCK_TMO,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       req_restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2(max3(RST_CYC, LOCK_FILT, LOCK_TMO));

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TMO - 1);
  // RUN is taken on the edge where the filter count would reach LOCK_FILT-1, so that
  // the WAIT_LOCK cycle plus the FILTER cycles add up to LOCK_FILT locked cycles.
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 2);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  logic lk;

  sync2 u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  pll_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       retry_reg, retry_next;
  logic             boot_reg;
  logic             pll_rst_reg, sys_rst_n_reg, ready_reg, fault_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    if (req_restart) begin
      state_next = RESET_PLL;
      cnt_next   = '0;
      retry_next = '0;
    end else if (boot_reg) begin
      // first edge after reset release restarts the pulse so it is a full RST_CYC long
      state_next = RESET_PLL;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        RESET_PLL: begin
          if (cnt_reg == RST_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_next = FILTER;
            cnt_next   = '0;
          end else if (cnt_reg == TMO_LAST) begin
            cnt_next = '0;
            if (retry_reg < RETRY_MAX) begin
              state_next = RESET_PLL;
              retry_next = retry_reg + 2'd1;
            end else begin
              state_next = FAULT;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        FILTER: begin
          if (!lk) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == FILT_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
            retry_next = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            state_next = RESET_PLL;
            cnt_next   = '0;
          end
        end
        FAULT: begin
          cnt_next = '0;
        end
        default: begin
          state_next = RESET_PLL;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RESET_PLL;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      boot_reg      <= 1'b1;
      pll_rst_reg   <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      boot_reg      <= 1'b0;
      pll_rst_reg   <= (state_next == RESET_PLL) || (state_next == FAULT);
      sys_rst_n_reg <= (state_next == RUN);
      ready_reg     <= (state_next == RUN);
      fault_reg     <= (state_next == FAULT);
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign sys_rst_n = sys_rst_n_reg;
  assign ready     = ready_reg;
  assign fault     = fault_reg;
  assign retry_cnt = retry_reg;
  assign state     = state_reg;

endmodule
